// File: rtl/bbq_wtime_calc_pkg.sv
// Shared types and helpers for the bank-queue wait-time calculator.
package bbq_pkg;

   // Controller state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_SERVICE_TIME = 3;

   // Numerator width: SERVICE_TIME*(P+T-1) always fits in this many bits
   function automatic int unsigned calc_num_w(input int unsigned pcount_w,
                                              input int unsigned tcount_w,
                                              input int unsigned service_time);
      return pcount_w + tcount_w + $clog2(service_time + 1);
   endfunction

endpackage

// File: rtl/bbq_wtime_calc_if.sv
// Start/done handshake between the queue counters and the wait-time calculator.
interface bbq_wtime_calc_if #(
   parameter int unsigned PCOUNT_W = 3,
   parameter int unsigned TCOUNT_W = 2,
   parameter int unsigned WTIME_W  = 5
) ();

   logic                start;
   logic [PCOUNT_W-1:0] pcount;
   logic [TCOUNT_W-1:0] tcount;
   logic                busy;
   logic                done;
   logic [WTIME_W-1:0]  wtime;
   logic                sat;

   modport master (
      output start, pcount, tcount,
      input  busy, done, wtime, sat
   );

   modport slave (
      input  start, pcount, tcount,
      output busy, done, wtime, sat
   );

endinterface

// File: rtl/bbq_serial_div.sv
// Generic serial restoring divider, one quotient bit per step, MSB first.
// The load cycle performs the first step directly on the num/den inputs, so
// count_done rises after NUM_W steps counting the load.
module bbq_serial_div #(
   parameter int unsigned NUM_W = 7,
   parameter int unsigned D_W   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [NUM_W-1:0] num,
   input  logic [D_W-1:0]   den,
   output logic [NUM_W-1:0] quotient,
   output logic             count_done
);

   localparam int unsigned CNT_W = $clog2(NUM_W + 1);
   localparam int unsigned R_W   = D_W + 1;

   logic [NUM_W-1:0] n_q, q_q;
   logic [D_W-1:0]   d_q;
   logic [R_W-1:0]   rem_q;
   logic [CNT_W-1:0] cnt_q;

   logic [NUM_W-1:0] src_n_c, src_q_c;
   logic [D_W-1:0]   src_d_c;
   logic [R_W-1:0]   src_rem_c, rem_nxt_c;
   logic [R_W:0]     rem_sh_c, den_ext_c;
   logic             qbit_c;
   logic [CNT_W-1:0] cnt_nxt_c;

   // One restoring step on either fresh operands (load) or the running state
   always_comb begin
      src_n_c   = load ? num : n_q;
      src_d_c   = load ? den : d_q;
      src_rem_c = load ? '0  : rem_q;
      src_q_c   = load ? '0  : q_q;
      rem_sh_c  = {src_rem_c, src_n_c[NUM_W-1]};
      den_ext_c = (R_W+1)'(src_d_c);
      qbit_c    = (rem_sh_c >= den_ext_c);
      rem_nxt_c = qbit_c ? R_W'(rem_sh_c - den_ext_c) : R_W'(rem_sh_c);
      cnt_nxt_c = load ? CNT_W'(1) : cnt_q + CNT_W'(1);
   end

   // Divider datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q        <= '0;
         d_q        <= '0;
         rem_q      <= '0;
         q_q        <= '0;
         cnt_q      <= '0;
         count_done <= 1'b0;
      end else if (load || step) begin
         n_q        <= src_n_c << 1;
         d_q        <= src_d_c;
         rem_q      <= rem_nxt_c;
         q_q        <= (src_q_c << 1) | NUM_W'(qbit_c);
         cnt_q      <= cnt_nxt_c;
         count_done <= (cnt_nxt_c == CNT_W'(NUM_W));
      end
   end

   assign quotient = q_q;

endmodule

// File: rtl/bbq_wtime_calc.sv
// Wait-time calculator: wtime = floor(SERVICE_TIME*(P+T-1)/T), saturated to
// WTIME_W bits. Zero people or zero tellers bypass the divider with result 0.
// Optional macro BBQ_WTIME_CACHE_EN: a repeated (pcount,tcount) pair re-pulses
// done with the held result instead of dividing again.
module bbq_wtime_calc
   import bbq_pkg::*;
#(
   parameter int unsigned PCOUNT_W     = 3,
   parameter int unsigned TCOUNT_W     = 2,
   parameter int unsigned SERVICE_TIME = DEFAULT_SERVICE_TIME,
   parameter int unsigned WTIME_W      = 5,
   parameter int unsigned NUM_W        = calc_num_w(PCOUNT_W, TCOUNT_W, SERVICE_TIME)
) (
   input logic             clk,
   input logic             rst,
   bbq_wtime_calc_if.slave bus
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] DIV  = ST_DIV;
   localparam logic [1:0] DONE = ST_DONE;

   localparam int unsigned CMP_W = (NUM_W > WTIME_W) ? NUM_W : WTIME_W;

   logic [1:0]          state, state_nxt;
   logic [PCOUNT_W-1:0] pcount_c;
   logic [TCOUNT_W-1:0] tcount_c;
   logic [NUM_W-1:0]    num_c;
   logic [NUM_W-1:0]    quotient;
   logic                div_done;
   logic                div_load_c, div_step_c;
   logic                res_upd_c, res_sat_c, sat_c, hit_c;
   logic [WTIME_W-1:0]  res_wtime_c;
   logic [CMP_W-1:0]    q_ext_c, wmax_c;

   logic                busy_q, done_q, sat_q;
   logic [WTIME_W-1:0]  wtime_q;

   assign pcount_c = bus.pcount;
   assign tcount_c = bus.tcount;
   assign num_c    = NUM_W'(SERVICE_TIME) *
                     (NUM_W'(pcount_c) + NUM_W'(tcount_c) - NUM_W'(1));

   bbq_serial_div #(
      .NUM_W (NUM_W),
      .D_W   (TCOUNT_W)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .load       (div_load_c),
      .step       (div_step_c),
      .num        (num_c),
      .den        (tcount_c),
      .quotient   (quotient),
      .count_done (div_done)
   );

   // Clip the quotient to the display width
   always_comb begin
      q_ext_c = CMP_W'(quotient);
      wmax_c  = CMP_W'({WTIME_W{1'b1}});
      sat_c   = (q_ext_c > wmax_c);
   end

`ifdef BBQ_WTIME_CACHE_EN
   logic [PCOUNT_W-1:0] last_p_q;
   logic [TCOUNT_W-1:0] last_t_q;
   logic                cache_vld_q;

   assign hit_c = cache_vld_q && (pcount_c == last_p_q) && (tcount_c == last_t_q);

   // Remember the pair being computed; it becomes valid once its result lands
   always_ff @(posedge clk) begin
      if (rst) begin
         last_p_q    <= '0;
         last_t_q    <= '0;
         cache_vld_q <= 1'b0;
      end else if ((state == IDLE) && bus.start && !hit_c) begin
         last_p_q    <= pcount_c;
         last_t_q    <= tcount_c;
         cache_vld_q <= 1'b0;
      end else if (res_upd_c) begin
         cache_vld_q <= 1'b1;
      end
   end
`else
   assign hit_c = 1'b0;
`endif

   // Next-state and datapath control
   always_comb begin
      state_nxt   = state;
      div_load_c  = 1'b0;
      div_step_c  = 1'b0;
      res_upd_c   = 1'b0;
      res_wtime_c = '0;
      res_sat_c   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (hit_c) begin
                  state_nxt = DONE;
               end else if ((pcount_c == '0) || (tcount_c == '0)) begin
                  state_nxt = DONE;
                  res_upd_c = 1'b1;
               end else begin
                  state_nxt  = DIV;
                  div_load_c = 1'b1;
               end
            end
         end
         DIV: begin
            if (div_done) begin
               state_nxt   = DONE;
               res_upd_c   = 1'b1;
               res_sat_c   = sat_c;
               res_wtime_c = sat_c ? '1 : WTIME_W'(q_ext_c);
            end else begin
               div_step_c = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Registered handshake outputs and result hold
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wtime_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         busy_q <= (state_nxt != IDLE);
         done_q <= (state_nxt == DONE);
         if (res_upd_c) begin
            wtime_q <= res_wtime_c;
            sat_q   <= res_sat_c;
         end
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.wtime = wtime_q;
   assign bus.sat   = sat_q;

endmodule

// File: tb/tb_bbq_wtime_calc.sv
// Scoreboard bench for bbq_wtime_calc: a default instance and a WTIME_W=4
// instance to exercise saturation. Honours BBQ_WTIME_CACHE_EN.
module tb_bbq_wtime_calc;

   localparam int LAT_DIV  = 8;
   localparam int LAT_ZERO = 1;
`ifdef BBQ_WTIME_CACHE_EN
   localparam int LAT_REPEAT = 1;
`else
   localparam int LAT_REPEAT = 8;
`endif

   typedef struct {
      int w;
      int s;
      int lat;
      int acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   // Hand-computed floor(3*(P+T-1)/T), rows T=1..3, columns P=1..7
   int exp_tbl [3][7] = '{'{3, 6, 9, 12, 15, 18, 21},
                          '{3, 4, 6, 7, 9, 10, 12},
                          '{3, 4, 5, 6, 7, 8, 9}};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bbq_wtime_calc_if #(.PCOUNT_W(3), .TCOUNT_W(2), .WTIME_W(5)) bus0 ();
   bbq_wtime_calc_if #(.PCOUNT_W(3), .TCOUNT_W(2), .WTIME_W(4)) bus1 ();

   bbq_wtime_calc #(.PCOUNT_W(3), .TCOUNT_W(2), .SERVICE_TIME(3), .WTIME_W(5)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   bbq_wtime_calc #(.PCOUNT_W(3), .TCOUNT_W(2), .SERVICE_TIME(3), .WTIME_W(4)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Wait for idle, push the expectation, then present one start pulse
   task automatic issue(input int inst, input int p, input int t, input int w,
                        input int s, input int lat, input bit push);
      int   n = 0;
      exp_t e;
      while (((inst == 0) ? bus0.busy : bus1.busy) && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL idle_wait: dut%0d still busy after %0d cycles", inst, n);
      end
      e.w = w; e.s = s; e.lat = lat; e.acc = cyc;
      if (push) begin
         if (inst == 0) q0.push_back(e);
         else           q1.push_back(e);
      end
      if (inst == 0) begin
         bus0.pcount = 3'(p);
         bus0.tcount = 2'(t);
         bus0.start  = 1'b1;
      end else begin
         bus1.pcount = 3'(p);
         bus1.tcount = 2'(t);
         bus1.start  = 1'b1;
      end
      @(negedge clk);
      bus0.start = 1'b0;
      bus1.start = 1'b0;
   endtask

   // Monitor: every done pulse pops and checks one expectation
   always @(negedge clk) begin
      if (bus0.done === 1'b1) begin
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut0_unexpected_done: wtime=%0d at cycle %0d", bus0.wtime, cyc);
         end else begin
            e0 = q0.pop_front();
            chk("dut0_wtime", int'(bus0.wtime), e0.w);
            chk("dut0_sat", int'(bus0.sat), e0.s);
            chk("dut0_latency", cyc - e0.acc, e0.lat);
         end
      end
      if (bus1.done === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut1_unexpected_done: wtime=%0d at cycle %0d", bus1.wtime, cyc);
         end else begin
            e1 = q1.pop_front();
            chk("dut1_wtime", int'(bus1.wtime), e1.w);
            chk("dut1_sat", int'(bus1.sat), e1.s);
            chk("dut1_latency", cyc - e1.acc, e1.lat);
         end
      end
   end

   initial begin
      int n;
      bus0.start = 1'b0; bus0.pcount = '0; bus0.tcount = '0;
      bus1.start = 1'b0; bus1.pcount = '0; bus1.tcount = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("reset_busy", int'(bus0.busy), 0);
      chk("reset_done", int'(bus0.done), 0);
      chk("reset_wtime", int'(bus0.wtime), 0);
      chk("reset_sat", int'(bus0.sat), 0);
      chk("reset_wtime_dut1", int'(bus1.wtime), 0);

      // Full legacy-table sweep, back to back
      for (int t = 1; t <= 3; t++)
         for (int p = 1; p <= 7; p++)
            issue(0, p, t, exp_tbl[t-1][p-1], 0, LAT_DIV, 1'b1);

      // Zero bypass: one-cycle latency and a single busy cycle
      issue(0, 0, 2, 0, 0, LAT_ZERO, 1'b1);
      chk("zero_busy_in_done", int'(bus0.busy), 1);
      @(negedge clk);
      chk("zero_busy_after", int'(bus0.busy), 0);
      issue(0, 5, 0, 0, 0, LAT_ZERO, 1'b1);

      // Overlapping start and input change during a divide are ignored
      issue(0, 7, 1, 21, 0, LAT_DIV, 1'b1);
      @(negedge clk);
      bus0.pcount = 3'd3;
      bus0.tcount = 2'd2;
      bus0.start  = 1'b1;
      @(negedge clk);
      bus0.start  = 1'b0;

      // Repeated pair
      issue(0, 5, 2, 9, 0, LAT_DIV, 1'b1);
      issue(0, 5, 2, 9, 0, LAT_REPEAT, 1'b1);

      // Reset in the middle of a divide aborts it silently
      issue(0, 4, 3, 6, 0, LAT_DIV, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", int'(bus0.busy), 0);
      chk("abort_done", int'(bus0.done), 0);
      chk("abort_wtime", int'(bus0.wtime), 0);
      issue(0, 5, 2, 9, 0, LAT_DIV, 1'b1);

      // Reset while idle forgets the last pair
      n = 0;
      while (bus0.busy && (n < 50)) begin @(negedge clk); n++; end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      issue(0, 5, 2, 9, 0, LAT_DIV, 1'b1);

      // Narrow output: saturation, then an in-range result clears sat
      issue(1, 7, 1, 15, 1, LAT_DIV, 1'b1);
      issue(1, 1, 3, 3, 0, LAT_DIV, 1'b1);

      // Drain the scoreboard
      n = 0;
      while (((q0.size() != 0) || (q1.size() != 0)) && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      if ((q0.size() != 0) || (q1.size() != 0)) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d and %0d results never arrived", q0.size(), q1.size());
      end
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
